// File: rtl/alu_div_seq_if.sv
// Divider request/response bundle between the execute stage and alu_div_seq.
// The master drives the operands and start pulse; the slave returns the results.
interface alu_div_seq_if;
    logic        start;
    logic        op_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        sign_ovf;

    modport master (
        output start, op_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, sign_ovf
    );

    modport slave (
        input  start, op_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, sign_ovf
    );
endinterface

// File: rtl/alu_div_seq.sv
// Sequential restoring divider: one trial subtraction per cycle on a shared
// 32-bit add/sub unit, with signed/unsigned modes and fixed special results.
module alu_div_seq #(
    parameter logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF,
    parameter int          ITERS     = 32
) (
    input logic         clk,
    input logic         rst,
    alu_div_seq_if.slave bus
);

    if (ITERS != 32) begin : g_bad_iters
        $error("alu_div_seq: ITERS must be 32");
    end

    localparam logic [4:0] LAST = 5'(ITERS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        sgn_q, sgn_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] dmag_q, dmag_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [31:0] r_q, r_d;
    logic [31:0] q_q, q_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic        dbz_q, dbz_d;
    logic        ovf_q, ovf_d;

    logic [31:0] add_a, add_b, add_res;
    logic        add_sub, add_co;
    logic [32:0] rs;
    logic        a_neg, b_neg, ok;

    // Shared add/sub unit; carry out of a subtraction means a >= b.
    always_comb begin
        {add_co, add_res} = {1'b0, add_a}
                          + {1'b0, add_b ^ {32{add_sub}}}
                          + {32'd0, add_sub};
    end

    // Next-state and datapath sequencing.
    always_comb begin
        state_d = state_q;
        sgn_d   = sgn_q;
        a_d     = a_q;
        b_d     = b_q;
        dmag_d  = dmag_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        add_a   = 32'd0;
        add_b   = 32'd0;
        add_sub = 1'b1;
        rs      = {r_q, q_q[31]};
        a_neg   = sgn_q & a_q[31];
        b_neg   = sgn_q & b_q[31];
        ok      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sgn_d   = bus.op_signed;
                    a_d     = bus.dividend;
                    b_d     = bus.divisor;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                dmag_d = b_neg ? (32'd0 - b_q) : b_q;
                qneg_d = a_neg ^ b_neg;
                rneg_d = a_neg;
                r_d    = 32'd0;
                q_d    = a_neg ? (32'd0 - a_q) : a_q;
                cnt_d  = 5'd0;
                if (b_q == 32'd0) begin
                    quot_d  = DIV0_QUOT;
                    rem_d   = a_q;
                    dbz_d   = 1'b1;
                    ovf_d   = 1'b0;
                    state_d = S_DONE;
                end else if (sgn_q && a_q == 32'h8000_0000
                             && b_q == 32'hFFFF_FFFF) begin
                    quot_d  = 32'h8000_0000;
                    rem_d   = 32'd0;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                add_a = rs[31:0];
                add_b = dmag_q;
                ok    = rs[32] | add_co;
                r_d   = ok ? add_res : rs[31:0];
                q_d   = {q_q[30:0], ok};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                add_a   = 32'd0;
                add_b   = q_q;
                quot_d  = qneg_q ? add_res : q_q;
                rem_d   = rneg_q ? (32'd0 - r_q) : r_q;
                dbz_d   = 1'b0;
                ovf_d   = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sgn_q   <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            dmag_q  <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            r_q     <= 32'd0;
            q_q     <= 32'd0;
            cnt_q   <= 5'd0;
            quot_q  <= 32'd0;
            rem_q   <= 32'd0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sgn_q   <= sgn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dmag_q  <= dmag_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy        = (state_q == S_PREP) || (state_q == S_ITER)
                           || (state_q == S_FIX);
    assign bus.done        = (state_q == S_DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.sign_ovf    = ovf_q;

endmodule
